temp_sr_reader: RTL and testbench

//  Host-side reader for the temperature sensor's serial count shifter, i.e. the other end of the shift_clk/sr_out link.
//  - Generates shift_clk_o and samples the serial sr_in stream.
//  - Assembles DATA_W-bit words and hands them off on a valid/ready interface.
//  - Sits in user_proj_example, feeding Wishbone-readable status/data registers.

---
 rtl/temp_sr_reader.sv | 149 ++++++++++++++
 tb/tb_temp_sr_reader.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_sr_reader.sv
// Host-side reader for the temperature sensor serial count shifter.
// Drives shift_clk_o, samples sr_in and hands words off on valid/ready.
module temp_sr_reader #(
  parameter int DATA_W    = 16,
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic              sr_in,
  output logic              shift_clk_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              overrun_o,
  input  logic              ovr_clr_i
);

  localparam int DW = $clog2(DIV);
  localparam int BW = $clog2(DATA_W);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [1:0]        sync_q, sync_d;
  logic              sclk_q, sclk_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic [DATA_W-1:0] cap_w;
  logic              div_end;

  assign div_end = (div_q == DIV_LAST);

  always_comb begin
    if (MSB_FIRST) begin
      cap_w = {sr_q[DATA_W-2:0], sync_q[1]};
    end else begin
      cap_w = {sync_q[1], sr_q[DATA_W-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    sync_d  = {sync_q[0], sr_in};
    sclk_d  = sclk_q;
    busy_d  = busy_q;
    data_d  = data_q;
    valid_d = valid_q & ~ready_i;
    ovr_d   = ovr_q & ~ovr_clr_i;
    unique case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        if (start_i) begin
          state_d = LOW;
          div_d   = '0;
          bit_d   = '0;
          busy_d  = 1'b1;
        end
      end
      LOW: begin
        if (div_end) begin
          sr_d    = cap_w;
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      HIGH: begin
        if (div_end) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            state_d = DONE;
            // A waiting word that is not taken now wins; the new one is lost.
            if (!valid_q || ready_i) begin
              data_d  = sr_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = LOW;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE: begin
        sclk_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      sync_q  <= '0;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      sync_q  <= sync_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign shift_clk_o = sclk_q;
  assign busy_o      = busy_q;
  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_temp_sr_reader.sv
// Bench for temp_sr_reader: MSB-first and LSB-first instances share
// one sensor model and are checked against a transaction-level model.
module tb_temp_sr_reader;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int RD = 2 * D * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic rdy = 1'b0;
  logic clr = 1'b0;
  logic sr_in;
  logic sclk_m, busy_m, val_m, ovr_m;
  logic sclk_l, busy_l, val_l, ovr_l;
  logic [W-1:0] data_m, data_l;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  temp_sr_reader #(.DATA_W(W), .DIV(D), .MSB_FIRST(1'b1)) u_msb (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .sr_in(sr_in),
    .shift_clk_o(sclk_m), .busy_o(busy_m), .data_o(data_m),
    .valid_o(val_m), .ready_i(rdy), .overrun_o(ovr_m), .ovr_clr_i(clr)
  );

  temp_sr_reader #(.DATA_W(W), .DIV(D), .MSB_FIRST(1'b0)) u_lsb (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .sr_in(sr_in),
    .shift_clk_o(sclk_l), .busy_o(busy_l), .data_o(data_l),
    .valid_o(val_l), .ready_i(rdy), .overrun_o(ovr_l), .ovr_clr_i(clr)
  );

  // Sensor: presents stream bit k after k rising edges of shift_clk.
  logic [W-1:0] sens_word = '0;
  int rise_cnt = 0;
  int base = 0;
  int sidx;
  always @(posedge sclk_m) rise_cnt <= rise_cnt + 1;
  always_comb begin
    sidx = rise_cnt - base;
    if (sidx >= 0 && sidx < W) sr_in = sens_word[W-1-sidx];
    else sr_in = 1'b0;
  end

  int vrise = 0;
  logic vprev = 1'b0;
  always @(posedge clk) begin
    vprev <= val_m;
    if (val_m && !vprev) vrise <= vrise + 1;
  end

  // Transaction-level model of the output side.
  logic mv = 1'b0;
  logic mo = 1'b0;
  logic [W-1:0] mdm = '0;
  logic [W-1:0] mdl = '0;

  function automatic logic [W-1:0] rev(input logic [W-1:0] w);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = w[W-1-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mstep(input bit dlv, input logic [W-1:0] w);
    bit ov_set;
    ov_set = dlv && mv && !rdy;
    if (rst) begin
      mv = 1'b0; mo = 1'b0; mdm = '0; mdl = '0;
    end else begin
      if (dlv) begin
        if (!mv || rdy) begin
          mdm = w; mdl = rev(w); mv = 1'b1;
        end
      end else if (mv && rdy) begin
        mv = 1'b0;
      end
      if (clr) mo = 1'b0;
      if (ov_set) mo = 1'b1;
    end
    tick();
  endtask

  // mode 0: ready low, 1: ready high, 2: ready only on the completing cycle
  task automatic run_read(input logic [W-1:0] w, input int mode);
    sens_word = w;
    base = rise_cnt;
    start = 1'b1;
    mstep(1'b0, w);
    start = 1'b0;
    for (int c = 1; c <= RD; c++) begin
      if (mode == 0) rdy = 1'b0;
      else if (mode == 1) rdy = 1'b1;
      else rdy = (c == RD);
      mstep(c == RD, w);
    end
    if (mode == 2) rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; rdy = 1'b1; clr = 1'b0;
    mstep(1'b0, '0);
    mstep(1'b0, '0);
    total++;
    if ({sclk_m, busy_m, val_m, ovr_m, data_m} !== '0 ||
        {sclk_l, busy_l, val_l, ovr_l, data_l} !== '0) begin
      bad++;
      $display("FAIL reset_out: got %b%b%b%b %h / %b%b%b%b %h want all zero",
               sclk_m, busy_m, val_m, ovr_m, data_m,
               sclk_l, busy_l, val_l, ovr_l, data_l);
    end
    rst = 1'b0; start = 1'b0; rdy = 1'b0;
    mstep(1'b0, '0);
    total++;
    if (busy_m !== 1'b0 || busy_l !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy %b/%b want 0", busy_m, busy_l);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] w;
    int r0, first_rise, last_rise;
    w = 16'hA5C3;
    sens_word = w; base = rise_cnt; r0 = rise_cnt;
    first_rise = -1; last_rise = -1;
    rdy = 1'b1; start = 1'b1;
    mstep(1'b0, w);
    start = 1'b0;
    for (int c = 1; c <= RD + 2; c++) begin
      total++;
      if (busy_m !== (c <= RD + 1) || busy_l !== (c <= RD + 1)) begin
        bad++;
        $display("FAIL basic_busy cyc %0d: got %b/%b want %b",
                 c, busy_m, busy_l, c <= RD + 1);
      end
      total++;
      if (val_m !== (c == RD + 1) || val_l !== (c == RD + 1)) begin
        bad++;
        $display("FAIL basic_valid cyc %0d: got %b/%b want %b",
                 c, val_m, val_l, c == RD + 1);
      end
      if (c == RD + 1) begin
        total++;
        if (data_m !== 16'hA5C3 || data_l !== 16'hC3A5) begin
          bad++;
          $display("FAIL basic_data: got %h/%h want a5c3/c3a5",
                   data_m, data_l);
        end
      end
      if (sclk_m && first_rise < 0) first_rise = c;
      if (sclk_m) last_rise = c;
      mstep(c == RD, w);
    end
    total++;
    if (rise_cnt - r0 != W) begin
      bad++;
      $display("FAIL basic_rises: got %0d want %0d", rise_cnt - r0, W);
    end
    total++;
    if (first_rise != D + 1 || last_rise - first_rise != 2 * D * (W - 1) + D - 1) begin
      bad++;
      $display("FAIL basic_period: first high %0d last high %0d want %0d %0d",
               first_rise, last_rise, D + 1, D + 1 + 2 * D * (W - 1) + D - 1);
    end
    rdy = 1'b0;
  endtask

  task automatic test_overrun();
    rdy = 1'b0;
    run_read(16'h1234, 0);
    mstep(1'b0, '0);
    run_read(16'hBEEF, 0);
    total++;
    if (val_m !== 1'b1 || data_m !== 16'h1234 || data_l !== rev(16'h1234)) begin
      bad++;
      $display("FAIL ovr_keep: v=%b d=%h/%h want 1 1234/%h",
               val_m, data_m, data_l, rev(16'h1234));
    end
    total++;
    if (ovr_m !== 1'b1 || ovr_l !== 1'b1) begin
      bad++;
      $display("FAIL ovr_set: got %b/%b want 1", ovr_m, ovr_l);
    end
    clr = 1'b1;
    mstep(1'b0, '0);
    clr = 1'b0;
    total++;
    if (ovr_m !== 1'b0 || ovr_l !== 1'b0 || val_m !== 1'b1) begin
      bad++;
      $display("FAIL ovr_clr: ovr %b/%b v=%b want 0/0 1", ovr_m, ovr_l, val_m);
    end
    rdy = 1'b1;
    mstep(1'b0, '0);
    rdy = 1'b0;
    total++;
    if (val_m !== 1'b0 || val_l !== 1'b0) begin
      bad++;
      $display("FAIL ovr_drain: valid %b/%b want 0", val_m, val_l);
    end
  endtask

  task automatic test_ready_at_done();
    rdy = 1'b0;
    run_read(16'h0F0F, 0);
    mstep(1'b0, '0);
    run_read(16'h8421, 2);
    total++;
    if (val_m !== 1'b1 || data_m !== 16'h8421 || data_l !== rev(16'h8421)) begin
      bad++;
      $display("FAIL rdy_done_data: v=%b d=%h/%h want 1 8421/%h",
               val_m, data_m, data_l, rev(16'h8421));
    end
    total++;
    if (ovr_m !== 1'b0 || ovr_l !== 1'b0) begin
      bad++;
      $display("FAIL rdy_done_ovr: got %b/%b want 0", ovr_m, ovr_l);
    end
    rdy = 1'b1;
    mstep(1'b0, '0);
    rdy = 1'b0;
    mstep(1'b0, '0);
    total++;
    if (val_m !== 1'b0) begin
      bad++;
      $display("FAIL rdy_done_take: valid %b want 0", val_m);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w;
    int r0;
    rdy = 1'b1;
    w = 16'h6B1D;
    sens_word = w; base = rise_cnt;
    start = 1'b1;
    mstep(1'b0, w);
    start = 1'b0;
    for (int c = 1; c < 60; c++) mstep(1'b0, w);
    rst = 1'b1;
    mstep(1'b0, w);
    rst = 1'b0;
    total++;
    if ({sclk_m, busy_m, val_m, ovr_m, data_m} !== '0 ||
        {sclk_l, busy_l, val_l, ovr_l, data_l} !== '0) begin
      bad++;
      $display("FAIL rst_mid: got %b%b%b%b %h / %b%b%b%b %h want all zero",
               sclk_m, busy_m, val_m, ovr_m, data_m,
               sclk_l, busy_l, val_l, ovr_l, data_l);
    end
    mstep(1'b0, w);
    w = W'($urandom);
    r0 = rise_cnt;
    run_read(w, 1);
    total++;
    if (val_m !== 1'b1 || data_m !== w || data_l !== rev(w)) begin
      bad++;
      $display("FAIL rst_clean: v=%b d=%h/%h want 1 %h/%h",
               val_m, data_m, data_l, w, rev(w));
    end
    total++;
    if (rise_cnt - r0 != W) begin
      bad++;
      $display("FAIL rst_rises: got %0d want %0d", rise_cnt - r0, W);
    end
    mstep(1'b0, '0);
    rdy = 1'b0;
  endtask

  task automatic test_ignored_start();
    logic [W-1:0] w;
    int r0, v0;
    rdy = 1'b1;
    w = W'($urandom);
    mstep(1'b0, '0);
    sens_word = w; base = rise_cnt;
    r0 = rise_cnt; v0 = vrise;
    start = 1'b1;
    mstep(1'b0, w);
    for (int c = 1; c <= RD + 1; c++) begin
      start = (c == 10 || c == 50 || c == RD + 1);
      mstep(c == RD, w);
    end
    start = 1'b0;
    total++;
    if (busy_m !== 1'b0 || busy_l !== 1'b0) begin
      bad++;
      $display("FAIL ign_busy: got %b/%b want 0", busy_m, busy_l);
    end
    mstep(1'b0, '0);
    mstep(1'b0, '0);
    total++;
    if (rise_cnt - r0 != W) begin
      bad++;
      $display("FAIL ign_rises: got %0d want %0d", rise_cnt - r0, W);
    end
    total++;
    if (vrise - v0 != 1) begin
      bad++;
      $display("FAIL ign_valid_events: got %0d want 1", vrise - v0);
    end
    total++;
    if (data_m !== w || data_l !== rev(w)) begin
      bad++;
      $display("FAIL ign_data: got %h/%h want %h/%h", data_m, data_l, w, rev(w));
    end
    rdy = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    int rate;
    for (int n = 0; n < 6; n++) begin
      rate = (n % 2 == 1) ? 3 : 127;
      w = W'($urandom);
      sens_word = w; base = rise_cnt;
      start = 1'b1;
      rdy = ($urandom_range(0, rate) == 0);
      clr = ($urandom_range(0, 31) == 0);
      mstep(1'b0, w);
      start = 1'b0;
      for (int c = 1; c <= RD + 1; c++) begin
        total++;
        if ({val_m, ovr_m, data_m, busy_m, val_l, ovr_l, data_l} !==
            {mv, mo, mdm, 1'b1, mv, mo, mdl}) begin
          bad++;
          $display("FAIL rand_out rd %0d cyc %0d: got v=%b o=%b b=%b d=%h/%h want v=%b o=%b b=1 d=%h/%h",
                   n, c, val_m, ovr_m, busy_m, data_m, data_l, mv, mo, mdm, mdl);
        end
        rdy = ($urandom_range(0, rate) == 0);
        clr = ($urandom_range(0, 31) == 0);
        mstep(c == RD, w);
      end
    end
    rdy = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_ready_at_done();
    test_reset_mid();
    test_ignored_start();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
